// File: rtl/pcie_datalink_pkg.sv
// Shared PCIe data-link definitions: link state encoding, FC credit classes and
// TLP header decode helpers used by the transmit credit gate.
package pcie_datalink_pkg;

  localparam logic [1:0] DL_INACTIVE = 2'b00;
  localparam logic [1:0] DL_INIT     = 2'b01;
  localparam logic [1:0] DL_ACTIVE   = 2'b11;

  localparam logic [4:0] TLP_TYPE_MEM     = 5'b00000;
  localparam logic [3:0] TLP_TYPE_CPL_PFX = 4'b0101;
  localparam logic [1:0] TLP_TYPE_MSG_PFX = 2'b10;

  typedef enum logic [1:0] {
    FC_POSTED,
    FC_NONPOSTED,
    FC_CPL
  } fc_class_e;

  typedef enum logic [1:0] {
    ST_WAIT_INIT,
    ST_HDR,
    ST_FWD
  } gate_state_e;

  function automatic fc_class_e get_tlp_fc_class(input logic has_data,
                                                 input logic [4:0] tlp_type);
    fc_class_e cls;
    if (tlp_type[4:1] == TLP_TYPE_CPL_PFX)
      cls = FC_CPL;
    else if ((has_data && tlp_type == TLP_TYPE_MEM) || tlp_type[4:3] == TLP_TYPE_MSG_PFX)
      cls = FC_POSTED;
    else
      cls = FC_NONPOSTED;
    return cls;
  endfunction

  // A length field of zero encodes 1024 DW, which is 256 data credits.
  function automatic logic [8:0] get_tlp_data_credits(input logic has_data,
                                                      input logic [9:0] length);
    logic [10:0] rounded;
    rounded = {1'b0, length} + 11'd3;
    if (!has_data)
      return 9'd0;
    else if (length == 10'd0)
      return 9'd256;
    else
      return rounded[10:2];
  endfunction

endpackage

// File: rtl/tlp_fc_credit_gate_if.sv
// AXI-Stream style TLP bus shared by the credit gate's input and output sides.
interface tlp_fc_credit_gate_if #(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 3,
  parameter int S_COUNT    = 1
);
  logic [DATA_WIDTH-1:0] tdata;
  logic [KEEP_WIDTH-1:0] tkeep;
  logic [S_COUNT-1:0]    tvalid;
  logic [S_COUNT-1:0]    tlast;
  logic [USER_WIDTH-1:0] tuser;
  logic [S_COUNT-1:0]    tready;

  modport master (output tdata, tkeep, tvalid, tlast, tuser, input tready);
  modport slave  (input tdata, tkeep, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/tlp_fc_classifier.sv
// Combinational decode of TLP header DW0 into flow-control class and data credit need.
module tlp_fc_classifier
  import pcie_datalink_pkg::*;
(
  input  logic [31:0] dw0,
  output fc_class_e   fc_class,
  output logic        has_data,
  output logic [8:0]  data_credits
);

  logic dw0_unused;

  assign has_data     = dw0[30];
  assign fc_class     = get_tlp_fc_class(dw0[30], dw0[28:24]);
  assign data_credits = get_tlp_data_credits(dw0[30], dw0[9:0]);
  assign dw0_unused   = ^{dw0[31], dw0[29], dw0[23:10]};

endmodule

// File: rtl/tlp_fc_credit_gate.sv
// Transmit flow-control gate: holds TLP headers until the advertised posted /
// non-posted credit limits allow them, and tracks credits consumed.
module tlp_fc_credit_gate
  import pcie_datalink_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 3,
  parameter int S_COUNT    = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  link_status_i,
  input  logic        fc_init_done_i,
  input  logic [7:0]  tx_fc_ph_i,
  input  logic [11:0] tx_fc_pd_i,
  input  logic [7:0]  tx_fc_nph_i,
  input  logic [11:0] tx_fc_npd_i,
  tlp_fc_credit_gate_if.slave  s_axis,
  tlp_fc_credit_gate_if.master m_axis,
  output logic [7:0]  fc_ph_consumed_o,
  output logic [11:0] fc_pd_consumed_o,
  output logic [7:0]  fc_nph_consumed_o,
  output logic [11:0] fc_npd_consumed_o,
  output logic        credit_stall_o
);

  if (DATA_WIDTH < 32 || KEEP_WIDTH != DATA_WIDTH / 8 || USER_WIDTH < 1 || S_COUNT < 1) begin : g_param_check
    $error("tlp_fc_credit_gate: unsupported parameter combination");
  end

  gate_state_e state, state_next;
  fc_class_e   fc_class;
  logic        has_data;
  logic [8:0]  data_credits;
  logic [11:0] req;
  logic        link_up, pass, hdr_fire, beat_fire, clear_cnt;
  logic [7:0]  ph_gap, nph_gap;
  logic [11:0] pd_gap, npd_gap;

  tlp_fc_classifier u_classifier (
    .dw0          (s_axis.tdata[31:0]),
    .fc_class     (fc_class),
    .has_data     (has_data),
    .data_credits (data_credits)
  );

  assign link_up   = (link_status_i == DL_ACTIVE);
  assign req       = has_data ? {3'b000, data_credits} : 12'd0;
  assign ph_gap    = tx_fc_ph_i  - fc_ph_consumed_o  - 8'd1;
  assign nph_gap   = tx_fc_nph_i - fc_nph_consumed_o - 8'd1;
  assign pd_gap    = tx_fc_pd_i  - fc_pd_consumed_o  - req;
  assign npd_gap   = tx_fc_npd_i - fc_npd_consumed_o - req;
  assign beat_fire = s_axis.tvalid[0] & m_axis.tready[0] & pass;
  assign hdr_fire  = beat_fire & (state == ST_HDR);

  assign m_axis.tdata  = s_axis.tdata;
  assign m_axis.tkeep  = s_axis.tkeep;
  assign m_axis.tlast  = s_axis.tlast;
  assign m_axis.tuser  = s_axis.tuser;
  assign m_axis.tvalid = s_axis.tvalid & {S_COUNT{pass}};
  assign s_axis.tready = m_axis.tready & {S_COUNT{pass}};

  always_ff @(posedge clk_i) begin
    if (rst_i) state <= ST_WAIT_INIT;
    else       state <= state_next;
  end

  // Credit checks use modular distance so wrapped counters compare correctly;
  // a dropped link in ST_HDR blocks the header and clears accounting.
  always_comb begin
    state_next     = state;
    pass           = 1'b0;
    credit_stall_o = 1'b0;
    clear_cnt      = 1'b0;
    case (state)
      ST_WAIT_INIT: begin
        if (link_up && fc_init_done_i) state_next = ST_HDR;
      end
      ST_HDR: begin
        if (!link_up) begin
          state_next = ST_WAIT_INIT;
          clear_cnt  = 1'b1;
        end else begin
          case (fc_class)
            FC_POSTED:    pass = (ph_gap  <= 8'd128) && (pd_gap  <= 12'd2048);
            FC_NONPOSTED: pass = (nph_gap <= 8'd128) && (npd_gap <= 12'd2048);
            default:      pass = 1'b1;
          endcase
          credit_stall_o = s_axis.tvalid[0] & ~pass;
          if (beat_fire && !s_axis.tlast[0]) state_next = ST_FWD;
        end
      end
      ST_FWD: begin
        pass = 1'b1;
        if (beat_fire && s_axis.tlast[0]) begin
          state_next = link_up ? ST_HDR : ST_WAIT_INIT;
          clear_cnt  = ~link_up;
        end
      end
      default: state_next = ST_WAIT_INIT;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_cnt) begin
      fc_ph_consumed_o  <= 8'd0;
      fc_pd_consumed_o  <= 12'd0;
      fc_nph_consumed_o <= 8'd0;
      fc_npd_consumed_o <= 12'd0;
    end else if (hdr_fire) begin
      if (fc_class == FC_POSTED) begin
        fc_ph_consumed_o <= fc_ph_consumed_o + 8'd1;
        fc_pd_consumed_o <= fc_pd_consumed_o + req;
      end else if (fc_class == FC_NONPOSTED) begin
        fc_nph_consumed_o <= fc_nph_consumed_o + 8'd1;
        fc_npd_consumed_o <= fc_npd_consumed_o + req;
      end
    end
  end

endmodule

// File: tb/tb_tlp_fc_credit_gate.sv
// Directed self-checking bench for tlp_fc_credit_gate with hand-computed expectations.
module tb_tlp_fc_credit_gate;
  import pcie_datalink_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [1:0]  link;
  logic        init_done;
  logic [7:0]  ph_lim, nph_lim;
  logic [11:0] pd_lim, npd_lim;
  logic [7:0]  ph_cons, nph_cons;
  logic [11:0] pd_cons, npd_cons;
  logic        stall;

  int testCount = 0;
  int failCount = 0;
  int beat;
  logic [7:0]  exp_ph;
  logic [11:0] exp_pd;
  logic [31:0] beat_data;
  logic [8:0]  req;
  logic [9:0]  len;

  tlp_fc_credit_gate_if s_if ();
  tlp_fc_credit_gate_if m_if ();

  tlp_fc_credit_gate dut (
    .clk_i             (clk),
    .rst_i             (rst),
    .link_status_i     (link),
    .fc_init_done_i    (init_done),
    .tx_fc_ph_i        (ph_lim),
    .tx_fc_pd_i        (pd_lim),
    .tx_fc_nph_i       (nph_lim),
    .tx_fc_npd_i       (npd_lim),
    .s_axis            (s_if),
    .m_axis            (m_if),
    .fc_ph_consumed_o  (ph_cons),
    .fc_pd_consumed_o  (pd_cons),
    .fc_nph_consumed_o (nph_cons),
    .fc_npd_consumed_o (npd_cons),
    .credit_stall_o    (stall)
  );

  function automatic logic [31:0] mkDw0(input logic [2:0] fmt, input logic [4:0] typ,
                                        input logic [9:0] length);
    return {fmt, typ, 14'd0, length};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic checkCounters(input string tag, input int ph, input int pd,
                               input int nph, input int npd);
    checkOutput({tag, " ph"},  32'(ph_cons),  32'(ph));
    checkOutput({tag, " pd"},  32'(pd_cons),  32'(pd));
    checkOutput({tag, " nph"}, 32'(nph_cons), 32'(nph));
    checkOutput({tag, " npd"}, 32'(npd_cons), 32'(npd));
  endtask

  // Called just after a falling edge; leaves the beat stable for the next rising edge.
  task automatic applyStimulus(input logic [31:0] data, input logic valid, input logic last);
    s_if.tdata  = data;
    s_if.tvalid = valid;
    s_if.tlast  = last;
    #1;
  endtask

  initial begin
    rst = 1'b1; link = DL_ACTIVE; init_done = 1'b1;
    ph_lim = 8'd4; pd_lim = 12'd64; nph_lim = 8'd4; npd_lim = 12'd0;
    s_if.tkeep = 4'hF; s_if.tuser = 3'b101;
    m_if.tready = 1'b1;
    applyStimulus(mkDw0(3'b010, 5'b00000, 10'd4), 1'b1, 1'b1);

    // Reset state
    @(negedge clk); @(negedge clk);
    checkOutput("rst m_tvalid", 32'(m_if.tvalid), 32'd0);
    checkOutput("rst s_tready", 32'(s_if.tready), 32'd0);
    checkOutput("rst stall", 32'(stall), 32'd0);
    checkCounters("rst", 0, 0, 0, 0);

    @(negedge clk); rst = 1'b0;
    applyStimulus(32'd0, 1'b0, 1'b0);

    // Posted header credits exhaust at the limit of 4
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      applyStimulus(mkDw0(3'b010, 5'b00000, 10'd4), 1'b1, 1'b1);
      checkOutput("t1 m_tvalid", 32'(m_if.tvalid), 32'd1);
      checkOutput("t1 s_tready", 32'(s_if.tready), 32'd1);
    end
    checkOutput("t1 tkeep", 32'(m_if.tkeep), 32'hF);
    checkOutput("t1 tuser", 32'(m_if.tuser), 32'd5);
    @(negedge clk);
    applyStimulus(mkDw0(3'b010, 5'b00000, 10'd4), 1'b1, 1'b1);
    checkOutput("t1 stall", 32'(stall), 32'd1);
    checkOutput("t1 blocked", 32'(m_if.tvalid), 32'd0);
    checkOutput("t1 blocked rdy", 32'(s_if.tready), 32'd0);
    checkCounters("t1 four", 4, 4, 0, 0);
    @(negedge clk); ph_lim = 8'd8;
    applyStimulus(mkDw0(3'b010, 5'b00000, 10'd4), 1'b1, 1'b1);
    checkOutput("t1 released", 32'(m_if.tvalid), 32'd1);
    checkOutput("t1 unstall", 32'(stall), 32'd0);
    @(negedge clk);
    applyStimulus(32'd0, 1'b0, 1'b0);
    checkCounters("t1 five", 5, 5, 0, 0);

    // Preload posted data consumed to 4090 with exact-fit limits
    exp_ph = 8'd5; exp_pd = 12'd5;
    for (int i = 0; i < 16; i++) begin
      len = (i < 15) ? 10'd0 : 10'd980;
      req = (i < 15) ? 9'd256 : 9'd245;
      @(negedge clk);
      ph_lim = exp_ph + 8'd1;
      pd_lim = exp_pd + {3'b000, req};
      applyStimulus(mkDw0(3'b011, 5'b00000, len), 1'b1, 1'b1);
      checkOutput("t2 preload", 32'(m_if.tvalid), 32'd1);
      exp_ph = exp_ph + 8'd1;
      exp_pd = exp_pd + {3'b000, req};
    end
    @(negedge clk);
    applyStimulus(32'd0, 1'b0, 1'b0);
    checkCounters("t2 preload", 21, 4090, 0, 0);
    @(negedge clk); ph_lim = 8'd22; pd_lim = 12'd4;
    applyStimulus(mkDw0(3'b010, 5'b00000, 10'd32), 1'b1, 1'b1);
    checkOutput("t2 wrap pass", 32'(m_if.tvalid), 32'd1);
    @(negedge clk);
    applyStimulus(32'd0, 1'b0, 1'b0);
    checkCounters("t2 wrap", 22, 2, 0, 0);

    // Length 0 needs 256 credits
    @(negedge clk); ph_lim = 8'd23; pd_lim = 12'd257;
    applyStimulus(mkDw0(3'b010, 5'b00000, 10'd0), 1'b1, 1'b1);
    checkOutput("t3 255 stall", 32'(stall), 32'd1);
    checkOutput("t3 255 valid", 32'(m_if.tvalid), 32'd0);
    @(negedge clk); pd_lim = 12'd258;
    applyStimulus(mkDw0(3'b010, 5'b00000, 10'd0), 1'b1, 1'b1);
    checkOutput("t3 256 valid", 32'(m_if.tvalid), 32'd1);
    @(negedge clk);
    applyStimulus(32'd0, 1'b0, 1'b0);
    checkCounters("t3", 23, 258, 0, 0);

    // Non-posted blocked, completions unaffected
    @(negedge clk); nph_lim = 8'd0;
    applyStimulus(mkDw0(3'b000, 5'b00000, 10'd1), 1'b1, 1'b1);
    checkOutput("t4 mrd stall", 32'(stall), 32'd1);
    checkOutput("t4 mrd valid", 32'(m_if.tvalid), 32'd0);
    @(negedge clk);
    applyStimulus(32'd0, 1'b0, 1'b0);
    @(negedge clk);
    applyStimulus(mkDw0(3'b010, 5'b01010, 10'd4), 1'b1, 1'b1);
    checkOutput("t4 cpld valid", 32'(m_if.tvalid), 32'd1);
    @(negedge clk); nph_lim = 8'd1;
    applyStimulus(mkDw0(3'b000, 5'b00000, 10'd1), 1'b1, 1'b1);
    checkCounters("t4 after cpld", 23, 258, 0, 0);
    checkOutput("t4 mrd pass", 32'(m_if.tvalid), 32'd1);
    @(negedge clk);
    applyStimulus(32'd0, 1'b0, 1'b0);
    checkCounters("t4 mrd", 23, 258, 1, 0);

    // Multi-beat MWr with toggling backpressure
    beat = 0;
    for (int c = 0; c < 12 && beat < 5; c++) begin
      @(negedge clk);
      ph_lim = 8'd24; pd_lim = 12'd259;
      m_if.tready = (c % 2 == 0);
      beat_data = (beat == 0) ? mkDw0(3'b010, 5'b00000, 10'd4) : 32'hD000_0000 + 32'(beat);
      applyStimulus(beat_data, 1'b1, beat == 4);
      checkOutput("t5 data", m_if.tdata, beat_data);
      checkOutput("t5 valid", 32'(m_if.tvalid), 32'd1);
      checkOutput("t5 ready", 32'(s_if.tready), 32'(m_if.tready));
      if (beat == 2) checkOutput("t5 mid ph", 32'(ph_cons), 32'd24);
      if (m_if.tready) beat++;
    end
    checkOutput("t5 beats", 32'(beat), 32'd5);
    @(negedge clk); m_if.tready = 1'b1;
    applyStimulus(mkDw0(3'b010, 5'b00000, 10'd4), 1'b1, 1'b1);
    checkOutput("t5 back in hdr", 32'(stall), 32'd1);
    checkCounters("t5", 24, 259, 1, 0);

    // Link drop mid-packet
    @(negedge clk); ph_lim = 8'd25; pd_lim = 12'd260;
    applyStimulus(mkDw0(3'b010, 5'b00000, 10'd4), 1'b1, 1'b0);
    checkOutput("t6 hdr", 32'(m_if.tvalid), 32'd1);
    for (int b = 1; b < 5; b++) begin
      @(negedge clk);
      link = DL_INACTIVE;
      applyStimulus(32'hE000_0000 + 32'(b), 1'b1, b == 4);
      checkOutput("t6 drain", 32'(m_if.tvalid), 32'd1);
      if (b == 1) checkCounters("t6 draining", 25, 260, 1, 0);
    end
    @(negedge clk);
    applyStimulus(mkDw0(3'b010, 5'b00000, 10'd4), 1'b1, 1'b1);
    checkOutput("t6 wait valid", 32'(m_if.tvalid), 32'd0);
    checkOutput("t6 wait ready", 32'(s_if.tready), 32'd0);
    checkOutput("t6 wait stall", 32'(stall), 32'd0);
    checkCounters("t6 cleared", 0, 0, 0, 0);

    // Reset mid-packet
    @(negedge clk); link = DL_ACTIVE;
    applyStimulus(32'd0, 1'b0, 1'b0);
    @(negedge clk); ph_lim = 8'd1; pd_lim = 12'd1;
    applyStimulus(mkDw0(3'b010, 5'b00000, 10'd4), 1'b1, 1'b0);
    checkOutput("t7 hdr", 32'(m_if.tvalid), 32'd1);
    @(negedge clk);
    applyStimulus(32'hF000_0001, 1'b1, 1'b0);
    checkCounters("t7 pre rst", 1, 1, 0, 0);
    @(negedge clk); rst = 1'b1;
    applyStimulus(32'hF000_0002, 1'b1, 1'b0);
    @(negedge clk);
    applyStimulus(32'hF000_0003, 1'b1, 1'b0);
    checkOutput("t7 rst valid", 32'(m_if.tvalid), 32'd0);
    checkOutput("t7 rst ready", 32'(s_if.tready), 32'd0);
    checkOutput("t7 rst stall", 32'(stall), 32'd0);
    checkCounters("t7 rst", 0, 0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
